// File: rtl/wei_addr_table_pp_if.sv
// ---------------------------------------------------------------------------
// wei_addr_table_pp_if
// Bus bundle for the double-buffered weight-address table.
//   write side : wr_val / wr_rdy / wr_data (LANES table entries per beat)
//   instr side : instr_val / instr_rdy / instr_peb / instr_pe / instr_len
//   read side  : rd_en / rd_addr / rd_peb / rd_pe towards the weight SRAM
// master = producer of write beats and instructions (config IF / PE side)
// slave  = the address table itself
// ---------------------------------------------------------------------------
interface wei_addr_table_pp_if #(
  parameter int ADDR_W  = 16,
  parameter int LANES   = 8,
  parameter int BURST_W = 3,
  parameter int PEB_W   = 4,
  parameter int PE_W    = 5
);
  logic                      wr_val;
  logic                      wr_rdy;
  logic [LANES*ADDR_W-1:0]   wr_data;
  logic                      instr_val;
  logic                      instr_rdy;
  logic [PEB_W-1:0]          instr_peb;
  logic [PE_W-1:0]           instr_pe;
  logic [BURST_W-1:0]        instr_len;
  logic                      rd_en;
  logic [ADDR_W-1:0]         rd_addr;
  logic [PEB_W-1:0]          rd_peb;
  logic [PE_W-1:0]           rd_pe;

  modport master (
    output wr_val, wr_data, instr_val, instr_peb, instr_pe, instr_len,
    input  wr_rdy, instr_rdy, rd_en, rd_addr, rd_peb, rd_pe
  );

  modport slave (
    input  wr_val, wr_data, instr_val, instr_peb, instr_pe, instr_len,
    output wr_rdy, instr_rdy, rd_en, rd_addr, rd_peb, rd_pe
  );
endinterface

// File: rtl/wei_addr_table_pp.sv
// ---------------------------------------------------------------------------
// wei_addr_table_pp
// Double-buffered weight-address table. One bank serves PE burst-read
// instructions while the other bank is filled with the next filter group's
// base addresses, so a group switch is just a bank swap.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   cfg_start    synchronous restart pulse, aborts all activity
//   cyc_num      pullback cycles per filter group (0 behaves as 1)
//   pullback     end of one read cycle; invalidates all resume cursors
//   bus          write beats, read instructions and SRAM read port
//   group_done   one-cycle pulse on the last pullback of a group
//   active_bank  bank currently serving reads
//   idx_err      sticky flag for an out-of-range PEB/PE index
// ---------------------------------------------------------------------------
module wei_addr_table_pp #(
  parameter int NUM_PEB = 16,
  parameter int PE_NUM  = 27,
  parameter int ADDR_W  = 16,
  parameter int LANES   = 8,
  parameter int BURST_W = 3,
  parameter int PEB_W   = 4,
  parameter int PE_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic [11:0]          cyc_num,
  input  logic                 pullback,
  wei_addr_table_pp_if.slave   bus,
  output logic                 group_done,
  output logic                 active_bank,
  output logic                 idx_err
);
  localparam int DEPTH  = NUM_PEB * PE_NUM;
  localparam int BEATS  = DEPTH / LANES;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  typedef enum logic [0:0] {
    ST_WAIT   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  active_bank_r;
  logic [1:0]            full_r;
  logic [BEAT_W-1:0]     beat_cnt_r;
  logic [11:0]           cyc_cnt_r;
  logic [BURST_W-1:0]    burst_cnt_r;
  logic                  rd_en_r;
  logic [ADDR_W-1:0]     rd_addr_r;
  logic [PEB_W-1:0]      rd_peb_r;
  logic [PE_W-1:0]       rd_pe_r;
  logic                  idx_err_r;
  logic [DEPTH-1:0]      cursor_vld_r;

  logic [ADDR_W-1:0]     base_mem [2][DEPTH];
  logic [ADDR_W-1:0]     cursor_mem [DEPTH];

  logic                  load_s;
  logic                  wr_rdy_s;
  logic                  wr_fire_s;
  logic [IDX_W-1:0]      wr_base_s;
  logic                  instr_rdy_s;
  logic                  instr_fire_s;
  logic                  idx_ok_s;
  logic [IDX_W-1:0]      idx_raw_s;
  logic [IDX_W-1:0]      idx_s;
  logic [ADDR_W-1:0]     start_s;
  logic                  rd_go_s;
  logic                  swap_s;
  logic                  group_end_s;
  logic [11:0]           cyc_last_s;

  // Handshakes, index decode and burst start address.
  always_comb begin
    load_s       = ~active_bank_r;
    wr_rdy_s     = !full_r[load_s] && !cfg_start;
    wr_fire_s    = bus.wr_val && wr_rdy_s;
    wr_base_s    = IDX_W'(beat_cnt_r) * IDX_W'(LANES);
    instr_fire_s = bus.instr_val && instr_rdy_s;
    idx_ok_s     = (32'(bus.instr_pe) < PE_NUM) && (32'(bus.instr_peb) < NUM_PEB);
    idx_raw_s    = IDX_W'(bus.instr_peb) * IDX_W'(PE_NUM) + IDX_W'(bus.instr_pe);
    // Park the index at 0 when out of range so the table is never read past DEPTH.
    idx_s        = idx_ok_s ? idx_raw_s : {IDX_W{1'b0}};
    start_s      = cursor_vld_r[idx_s] ? cursor_mem[idx_s] : base_mem[active_bank_r][idx_s];
    rd_go_s      = instr_fire_s && idx_ok_s && (bus.instr_len != {BURST_W{1'b0}});
    cyc_last_s   = (cyc_num == 12'd0) ? 12'd0 : (cyc_num - 12'd1);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_WAIT;
    end else if (cfg_start) begin
      state_r <= ST_WAIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_WAIT:   state_nxt_s = full_r[load_s] ? ST_ACTIVE : ST_WAIT;
      ST_ACTIVE: state_nxt_s = group_end_s ? ST_WAIT : ST_ACTIVE;
      default:   state_nxt_s = ST_WAIT;
    endcase
  end

  // FSM outputs: swap request, instruction ready, end-of-group detect.
  always_comb begin
    swap_s      = 1'b0;
    instr_rdy_s = 1'b0;
    group_end_s = 1'b0;
    case (state_r)
      ST_WAIT: begin
        swap_s = full_r[load_s] && !cfg_start;
      end
      ST_ACTIVE: begin
        instr_rdy_s = (burst_cnt_r == {BURST_W{1'b0}}) && !cfg_start;
        group_end_s = pullback && (cyc_cnt_r == cyc_last_s) && !cfg_start;
      end
      default: begin
        swap_s      = 1'b0;
        instr_rdy_s = 1'b0;
        group_end_s = 1'b0;
      end
    endcase
  end

  // Bank selection, full flags and write beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_bank_r <= 1'b0;
      full_r        <= 2'b00;
      beat_cnt_r    <= {BEAT_W{1'b0}};
    end else if (cfg_start) begin
      active_bank_r <= 1'b0;
      full_r        <= 2'b00;
      beat_cnt_r    <= {BEAT_W{1'b0}};
    end else begin
      if (wr_fire_s) begin
        if (beat_cnt_r == BEAT_LAST) begin
          beat_cnt_r     <= {BEAT_W{1'b0}};
          full_r[load_s] <= 1'b1;
        end else begin
          beat_cnt_r <= beat_cnt_r + {{(BEAT_W-1){1'b0}}, 1'b1};
        end
      end
      // A swap needs full[load] set, so it never coincides with a write beat.
      if (swap_s) begin
        active_bank_r         <= load_s;
        full_r[active_bank_r] <= 1'b0;
      end
    end
  end

  // Pullback counter within the current filter group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_r <= 12'd0;
    end else if (cfg_start || group_end_s) begin
      cyc_cnt_r <= 12'd0;
    end else if ((state_r == ST_ACTIVE) && pullback) begin
      cyc_cnt_r <= cyc_cnt_r + 12'd1;
    end
  end

  // Burst engine: rd_addr walks from the start address for instr_len beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_r     <= 1'b0;
      rd_addr_r   <= {ADDR_W{1'b0}};
      rd_peb_r    <= {PEB_W{1'b0}};
      rd_pe_r     <= {PE_W{1'b0}};
      burst_cnt_r <= {BURST_W{1'b0}};
    end else if (cfg_start) begin
      rd_en_r     <= 1'b0;
      rd_addr_r   <= {ADDR_W{1'b0}};
      rd_peb_r    <= {PEB_W{1'b0}};
      rd_pe_r     <= {PE_W{1'b0}};
      burst_cnt_r <= {BURST_W{1'b0}};
    end else if (rd_go_s) begin
      // burst_cnt holds beats still to come after the one being presented.
      rd_en_r     <= 1'b1;
      rd_addr_r   <= start_s;
      rd_peb_r    <= bus.instr_peb;
      rd_pe_r     <= bus.instr_pe;
      burst_cnt_r <= bus.instr_len - BURST_W'(1);
    end else if (burst_cnt_r != {BURST_W{1'b0}}) begin
      rd_addr_r   <= rd_addr_r + ADDR_W'(1);
      burst_cnt_r <= burst_cnt_r - BURST_W'(1);
    end else begin
      rd_en_r <= 1'b0;
    end
  end

  // Sticky out-of-range index flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_err_r <= 1'b0;
    end else if (cfg_start) begin
      idx_err_r <= 1'b0;
    end else if (instr_fire_s && !idx_ok_s) begin
      idx_err_r <= 1'b1;
    end
  end

  // Resume-cursor valid flags; a pullback invalidates every cursor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cursor_vld_r <= {DEPTH{1'b0}};
    end else if (cfg_start || pullback) begin
      cursor_vld_r <= {DEPTH{1'b0}};
    end else if (rd_go_s) begin
      cursor_vld_r[idx_s] <= 1'b1;
    end
  end

  // Base-address table storage, filled LANES entries per write beat.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      for (int i = 0; i < LANES; i++) begin
        base_mem[load_s][wr_base_s + IDX_W'(i)] <= bus.wr_data[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Resume-cursor storage: next address after the burst just started.
  always_ff @(posedge clk) begin
    if (rd_go_s) begin
      cursor_mem[idx_s] <= start_s + ADDR_W'(bus.instr_len);
    end
  end

  assign bus.wr_rdy    = wr_rdy_s;
  assign bus.instr_rdy = instr_rdy_s;
  assign bus.rd_en     = rd_en_r;
  assign bus.rd_addr   = rd_addr_r;
  assign bus.rd_peb    = rd_peb_r;
  assign bus.rd_pe     = rd_pe_r;
  assign group_done    = group_end_s;
  assign active_bank   = active_bank_r;
  assign idx_err       = idx_err_r;
endmodule

// File: tb/tb_wei_addr_table_pp.sv
// ---------------------------------------------------------------------------
// tb_wei_addr_table_pp
// Directed plus randomized bench for wei_addr_table_pp. A behavioural model
// keeps the expected table contents per bank, the resume cursors as plain
// arrays, the pullback count of the current group and the sticky error flag.
// ---------------------------------------------------------------------------
module tb_wei_addr_table_pp;
  localparam int NUM_PEB = 16;
  localparam int PE_NUM  = 27;
  localparam int ADDR_W  = 16;
  localparam int LANES   = 8;
  localparam int BURST_W = 3;
  localparam int PEB_W   = 4;
  localparam int PE_W    = 5;
  localparam int DEPTH   = NUM_PEB * PE_NUM;
  localparam int BEATS   = DEPTH / LANES;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic        pullback = 1'b0;
  logic [11:0] cyc_num = 12'd4095;
  logic        group_done;
  logic        active_bank;
  logic        idx_err;

  wei_addr_table_pp_if #(.ADDR_W(ADDR_W), .LANES(LANES), .BURST_W(BURST_W),
                         .PEB_W(PEB_W), .PE_W(PE_W)) bus ();

  wei_addr_table_pp #(.NUM_PEB(NUM_PEB), .PE_NUM(PE_NUM), .ADDR_W(ADDR_W), .LANES(LANES),
                      .BURST_W(BURST_W), .PEB_W(PEB_W), .PE_W(PE_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cyc_num(cyc_num),
    .pullback(pullback), .bus(bus), .group_done(group_done),
    .active_bank(active_bank), .idx_err(idx_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model state.
  logic [15:0] m_base [2][DEPTH];
  logic [15:0] m_cur [DEPTH];
  bit          m_cv [DEPTH];
  int          m_act;
  int          m_beat;
  int          m_pb;
  bit          m_serving;
  bit          m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_act = 0; m_beat = 0; m_pb = 0; m_serving = 1'b0; m_err = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_cv[i] = 1'b0;
  endtask

  task automatic write_beat(input logic [LANES*ADDR_W-1:0] d);
    int n;
    bit got;
    step();
    bus.wr_val = 1'b1; bus.wr_data = d; n = 0;
    @(negedge clk);
    while (bus.wr_rdy !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    got = (bus.wr_rdy === 1'b1);
    check("wr_rdy_wait", 32'(bus.wr_rdy), 32'(1));
    @(posedge clk); #1 bus.wr_val = 1'b0;
    if (got) begin
      for (int i = 0; i < LANES; i++) m_base[1 - m_act][m_beat*LANES + i] = d[i*ADDR_W +: ADDR_W];
      m_beat++;
      if (m_beat == BEATS) m_beat = 0;
    end
  endtask

  // mode 0: entry k = 0x100*k ; mode 1: random entries
  task automatic load_beats(input int mode, input int count);
    logic [LANES*ADDR_W-1:0] d;
    for (int b = 0; b < count; b++) begin
      for (int i = 0; i < LANES; i++) begin
        if (mode == 0) d[i*ADDR_W +: ADDR_W] = 16'((m_beat*LANES + i) * 256);
        else           d[i*ADDR_W +: ADDR_W] = 16'($urandom);
      end
      write_beat(d);
    end
  endtask

  task automatic wait_swap();
    int n;
    int exp;
    exp = 1 - m_act; n = 0;
    @(negedge clk);
    while (active_bank !== exp[0] && n < 10) begin @(negedge clk); n++; end
    check("swap_bank", 32'(active_bank), 32'(exp));
    m_act = exp; m_serving = 1'b1;
  endtask

  task automatic do_instr(input int peb, input int pe, input int len);
    int n;
    int idx;
    logic [15:0] a;
    step();
    bus.instr_val = 1'b1; bus.instr_peb = 4'(peb); bus.instr_pe = 5'(pe); bus.instr_len = 3'(len);
    n = 0;
    @(negedge clk);
    while (bus.instr_rdy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("instr_rdy_wait", 32'(bus.instr_rdy), 32'(1));
    @(posedge clk); #1 bus.instr_val = 1'b0;
    if (pe >= PE_NUM || peb >= NUM_PEB) begin
      m_err = 1'b1;
    end else if (len > 0) begin
      idx = peb * PE_NUM + pe;
      a = m_cv[idx] ? m_cur[idx] : m_base[m_act][idx];
      m_cur[idx] = a + 16'(len);
      m_cv[idx] = 1'b1;
      for (int k = 0; k < len; k++) begin
        @(negedge clk);
        check("rd_en_beat", 32'(bus.rd_en), 32'(1));
        check("rd_addr", 32'(bus.rd_addr), 32'(a));
        check("rd_peb", 32'(bus.rd_peb), 32'(peb));
        check("rd_pe", 32'(bus.rd_pe), 32'(pe));
        check("instr_rdy_in_burst", 32'(bus.instr_rdy), 32'(k == len - 1));
        a = a + 16'd1;
      end
    end
    @(negedge clk);
    check("rd_en_idle", 32'(bus.rd_en), 32'(0));
    check("idx_err", 32'(idx_err), 32'(m_err));
  endtask

  task automatic do_pullback();
    int eff;
    bit exp_gd;
    eff = (cyc_num == 12'd0) ? 1 : int'(cyc_num);
    exp_gd = m_serving && (m_pb == eff - 1);
    step();
    pullback = 1'b1;
    @(negedge clk);
    check("group_done", 32'(group_done), 32'(exp_gd));
    @(posedge clk); #1 pullback = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_cv[i] = 1'b0;
    if (m_serving) begin
      if (exp_gd) begin m_pb = 0; m_serving = 1'b0; end
      else m_pb++;
    end
    @(negedge clk);
    check("group_done_pulse", 32'(group_done), 32'(0));
  endtask

  task automatic rand_instr();
    int r;
    int peb;
    int pe;
    r = int'($urandom_range(0, 9));
    if (r < 5) begin
      peb = int'($urandom_range(0, 1)); pe = int'($urandom_range(0, 2));
    end else begin
      peb = int'($urandom_range(0, 15)); pe = int'($urandom_range(0, 26));
    end
    if (r == 9) pe = int'($urandom_range(27, 31));
    do_instr(peb, pe, int'($urandom_range(0, 7)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int peb;
    int pe;
    int idx;
    logic [15:0] a;
    int n;
    bus.wr_val = 1'b0; bus.wr_data = '0; bus.instr_val = 1'b0;
    bus.instr_peb = 4'd0; bus.instr_pe = 5'd0; bus.instr_len = 3'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_rd_en", 32'(bus.rd_en), 32'(0));
    check("rst_rd_addr", 32'(bus.rd_addr), 32'(0));
    check("rst_rd_peb", 32'(bus.rd_peb), 32'(0));
    check("rst_rd_pe", 32'(bus.rd_pe), 32'(0));
    check("rst_active_bank", 32'(active_bank), 32'(0));
    check("rst_idx_err", 32'(idx_err), 32'(0));
    check("rst_group_done", 32'(group_done), 32'(0));
    check("rst_wr_rdy", 32'(bus.wr_rdy), 32'(1));
    check("rst_instr_rdy", 32'(bus.instr_rdy), 32'(0));

    // First bank: entry k = 0x100*k, then swap to bank 1.
    load_beats(0, BEATS);
    wait_swap();
    check("instr_rdy_after_swap", 32'(bus.instr_rdy), 32'(1));

    // Directed cursor behaviour on PEB 1 / PE 2 (base 0x1D00).
    do_instr(1, 2, 3);
    do_instr(1, 2, 2);
    do_pullback();
    do_instr(1, 2, 1);
    do_instr(1, 2, 0);
    do_instr(1, 2, 2);
    do_instr(3, 27, 4);
    do_instr(0, 31, 1);

    // Random instructions with occasional pullbacks.
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 4) == 0 && m_pb < 5) do_pullback();
      else rand_instr();
    end

    // Preload bank 0 while bank 1 serves, then confirm the full bank blocks writes.
    load_beats(1, BEATS);
    step();
    bus.wr_val = 1'b1; bus.wr_data = {LANES{16'hDEAD}};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("wr_rdy_full", 32'(bus.wr_rdy), 32'(0));
    end
    @(posedge clk); #1 bus.wr_val = 1'b0;
    for (int t = 0; t < 5; t++) rand_instr();

    // Group end with a preloaded bank: two pullbacks, pulse, swap.
    cyc_num = 12'(m_pb + 2);
    do_pullback();
    do_pullback();
    wait_swap();
    check("wr_rdy_after_swap", 32'(bus.wr_rdy), 32'(1));
    for (int t = 0; t < 10; t++) rand_instr();

    // Group end without a preload: FSM waits until the last beat lands.
    cyc_num = 12'd2;
    do_pullback();
    do_pullback();
    check("instr_rdy_wait_state", 32'(bus.instr_rdy), 32'(0));
    load_beats(1, BEATS - 1);
    @(negedge clk);
    check("instr_rdy_partial_load", 32'(bus.instr_rdy), 32'(0));
    check("bank_hold_partial_load", 32'(active_bank), 32'(m_act));
    load_beats(1, 1);
    wait_swap();
    check("instr_rdy_after_late_swap", 32'(bus.instr_rdy), 32'(1));
    for (int t = 0; t < 6; t++) rand_instr();
    do_instr(0, 28, 1);

    // cfg_start in the middle of a len-7 burst.
    peb = 2; pe = 5; idx = peb * PE_NUM + pe;
    a = m_cv[idx] ? m_cur[idx] : m_base[m_act][idx];
    step();
    bus.instr_val = 1'b1; bus.instr_peb = 4'(peb); bus.instr_pe = 5'(pe); bus.instr_len = 3'd7;
    n = 0;
    @(negedge clk);
    while (bus.instr_rdy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("abort_instr_rdy_wait", 32'(bus.instr_rdy), 32'(1));
    @(posedge clk); #1 bus.instr_val = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("abort_rd_addr", 32'(bus.rd_addr), 32'(a + 16'(k)));
    end
    @(posedge clk); #1 cfg_start = 1'b1;
    @(negedge clk);
    check("abort_beat3_en", 32'(bus.rd_en), 32'(1));
    check("abort_beat3_addr", 32'(bus.rd_addr), 32'(a + 16'd2));
    check("abort_wr_rdy_low", 32'(bus.wr_rdy), 32'(0));
    check("abort_instr_rdy_low", 32'(bus.instr_rdy), 32'(0));
    @(posedge clk); #1 cfg_start = 1'b0;
    model_reset();
    @(negedge clk);
    check("abort_rd_en", 32'(bus.rd_en), 32'(0));
    check("abort_active_bank", 32'(active_bank), 32'(0));
    check("abort_instr_rdy", 32'(bus.instr_rdy), 32'(0));
    check("abort_wr_rdy", 32'(bus.wr_rdy), 32'(1));
    check("abort_idx_err", 32'(idx_err), 32'(0));
    check("abort_group_done", 32'(group_done), 32'(0));
    repeat (3) @(negedge clk);
    check("abort_rd_en_stays", 32'(bus.rd_en), 32'(0));

    // Reload after abort; cyc_num 0 ends the group on the first pullback.
    load_beats(1, BEATS);
    wait_swap();
    for (int t = 0; t < 4; t++) rand_instr();
    cyc_num = 12'd0;
    do_pullback();
    check("instr_rdy_after_cyc0_end", 32'(bus.instr_rdy), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
